// File: rtl/seq_sdffe_pkg.sv
// Shared sizing helpers, stage word type and tap-clamp rule for the SDFFE tap line.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
// Contents: idx_width() for sel/fill widths, word_t, TAP_CLAMP_LAST, clamp_tap().
package seq_sdffe_pkg;

  // $clog2 wrapper that never returns 0, so DEPTH=2 still gets a 1-bit select.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Default stage word. A package typedef cannot follow a module parameter,
  // so parameterised modules declare their own word type at WIDTH and this
  // one matches the default WIDTH.
  localparam int WORD_WIDTH_DEFAULT = 8;
  typedef logic [WORD_WIDTH_DEFAULT-1:0] word_t;

  // Out-of-range tap selects read the last stage rather than wrapping.
  localparam bit TAP_CLAMP_LAST = 1'b1;

  function automatic int clamp_tap(input int sel, input int depth);
    if (TAP_CLAMP_LAST && (sel > depth - 1)) begin
      return depth - 1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/seq_sdffe_tap_line_if.sv
// Bundles the tap line's control, data and status signals.
// Latency: n/a (wires only).
// Backpressure: none; en is the only flow control (low = hold).
// master drives en/d/in_valid/flush/sel and reads q/out_valid/fill_cnt; slave is the reverse.
interface seq_sdffe_tap_line_if
  import seq_sdffe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) ();

  localparam int SW = idx_width(DEPTH);
  localparam int FW = idx_width(DEPTH + 1);

  logic             en;
  logic [WIDTH-1:0] d;
  logic             in_valid;
  logic             flush;
  logic [SW-1:0]    sel;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic [FW-1:0]    fill_cnt;

  modport master (
    output en, d, in_valid, flush, sel,
    input  q, out_valid, fill_cnt
  );

  modport slave (
    input  en, d, in_valid, flush, sel,
    output q, out_valid, fill_cnt
  );

endinterface

// File: rtl/seq_sdffe_stage.sv
// One WIDTH-bit enabled register with sync reset to RESET_VAL, plus an optional valid bit.
// Latency: 1 enabled clk edge from d to q.
// Backpressure: holds data and valid while en is low; vclr clears valid regardless of en.
// Ports: clk, reset, en, d -> q; with SEQ_SDFFE_VALID_TRACK_EN also vin, vclr -> vout.
module seq_sdffe_stage
  import seq_sdffe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef SEQ_SDFFE_VALID_TRACK_EN
  ,
  input  logic             vin,
  input  logic             vclr,
  output logic             vout
`endif
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

`ifdef SEQ_SDFFE_VALID_TRACK_EN
  // vclr beats en: a flush drops the valid even on a shifting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      vout <= 1'b0;
    end else if (vclr) begin
      vout <= 1'b0;
    end else if (en) begin
      vout <= vin;
    end
  end
`endif

endmodule

// File: rtl/seq_sdffe_tap_line.sv
// Clock-enabled multi-bit delay line with a runtime tap select and optional valid tracking.
// Latency: d -> q after sel'+1 enabled edges (sel' = sel clamped to DEPTH-1); tap mux is combinational.
// Backpressure: en low freezes every stage, valid bit and the fill counter.
// Ports: clk, reset (sync, active-high), bus (slave: en, d, in_valid, flush, sel -> q, out_valid, fill_cnt).
// Build option SEQ_SDFFE_VALID_TRACK_EN: builds valid bits and fill counter; otherwise
// out_valid is tied 1, fill_cnt tied 0, in_valid/flush unused.
module seq_sdffe_tap_line
  import seq_sdffe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_sdffe_tap_line_if.slave  bus
);

  localparam int SW = idx_width(DEPTH);
  localparam int FW = idx_width(DEPTH + 1);

  typedef logic [WIDTH-1:0] stage_word_t;

  stage_word_t   stage_q [DEPTH];
  logic [SW-1:0] tap_idx;

`ifdef SEQ_SDFFE_VALID_TRACK_EN
  logic [DEPTH-1:0] v_q;
  logic [FW-1:0]    fill_q;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    stage_word_t din;
`ifdef SEQ_SDFFE_VALID_TRACK_EN
    logic        vin;
`endif
    if (i == 0) begin : g_head
      assign din = bus.d;
`ifdef SEQ_SDFFE_VALID_TRACK_EN
      assign vin = bus.in_valid;
`endif
    end else begin : g_tail
      assign din = stage_q[i-1];
`ifdef SEQ_SDFFE_VALID_TRACK_EN
      assign vin = v_q[i-1];
`endif
    end

    seq_sdffe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (bus.en),
      .d     (din),
      .q     (stage_q[i])
`ifdef SEQ_SDFFE_VALID_TRACK_EN
      ,
      .vin   (vin),
      .vclr  (bus.flush),
      .vout  (v_q[i])
`endif
    );
  end

  // Clamp in the integer domain so an unreachable out-of-range sel (DEPTH a
  // power of two) does not turn into a constant comparison on SW bits.
  assign tap_idx = SW'(clamp_tap(int'(bus.sel), DEPTH));
  assign bus.q   = stage_q[tap_idx];

`ifdef SEQ_SDFFE_VALID_TRACK_EN
  // Flush wins over the increment, so flush+en leaves the count at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= '0;
    end else if (bus.flush) begin
      fill_q <= '0;
    end else if (bus.en && (fill_q != FW'(DEPTH))) begin
      fill_q <= fill_q + FW'(1);
    end
  end

  assign bus.out_valid = v_q[tap_idx];
  assign bus.fill_cnt  = fill_q;
`else
  logic unused_vt;
  assign unused_vt     = &{1'b0, bus.in_valid, bus.flush};
  assign bus.out_valid = 1'b1;
  assign bus.fill_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_sdffe_tap_line.sv
// Bench for seq_sdffe_tap_line: an 8-deep and a 6-deep line driven with identical inputs.
// Expected outputs come from an input-history model (newest-first list of accepted words,
// plus a count of enabled shifts since reset/flush), checked every negedge.
module tb_seq_sdffe_tap_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_SDFFE_VALID_TRACK_EN
  localparam bit VT = 1'b1;
`else
  localparam bit VT = 1'b0;
`endif

  localparam logic [7:0] RV8 = 8'h3C;
  localparam logic [7:0] RV6 = 8'hC3;

  logic       rst;
  logic       en;
  logic       iv;
  logic       fl;
  logic [7:0] d;
  logic [2:0] sel;
  bit         chk_en = 1'b0;
  int         n_cmp  = 0;
  int         n_fail = 0;

  seq_sdffe_tap_line_if #(.WIDTH(8), .DEPTH(8)) b8 ();
  seq_sdffe_tap_line_if #(.WIDTH(8), .DEPTH(6)) b6 ();

  assign b8.en = en;  assign b8.d = d;  assign b8.in_valid = iv;
  assign b8.flush = fl;  assign b8.sel = sel;
  assign b6.en = en;  assign b6.d = d;  assign b6.in_valid = iv;
  assign b6.flush = fl;  assign b6.sel = sel;

  seq_sdffe_tap_line #(.WIDTH(8), .DEPTH(8), .RESET_VAL(RV8)) dut8 (
    .clk   (clk),
    .reset (rst),
    .bus   (b8)
  );

  seq_sdffe_tap_line #(.WIDTH(8), .DEPTH(6), .RESET_VAL(RV6)) dut6 (
    .clk   (clk),
    .reset (rst),
    .bus   (b6)
  );

  // ---------------- model ----------------
  logic [7:0] hd[$];   // accepted words, newest first
  bit         hv[$];   // their in_valid
  int         ep = 0;  // enabled shifts since last reset/flush

  always @(posedge clk) begin
    if (rst) begin
      hd.delete();
      hv.delete();
      ep = 0;
    end else begin
      if (en) begin
        hd.push_front(d);
        hv.push_front(iv);
        if (hd.size() > 8) begin
          void'(hd.pop_back());
          void'(hv.pop_back());
        end
        ep++;
      end
      if (fl) ep = 0;
    end
  end

  function automatic logic [7:0] exp_q(input int k, input logic [7:0] rv);
    return (k < hd.size()) ? hd[k] : rv;
  endfunction

  function automatic logic exp_v(input int k);
    if (!VT) return 1'b1;
    return (ep > k) && (k < hv.size()) && hv[k];
  endfunction

  function automatic int exp_f(input int depth);
    if (!VT) return 0;
    return (ep < depth) ? ep : depth;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    int k8;
    int k6;
    if (chk_en) begin
      k8 = (int'(sel) > 7) ? 7 : int'(sel);
      k6 = (int'(sel) > 5) ? 5 : int'(sel);
      check("q8",    32'(b8.q),         32'(exp_q(k8, RV8)));
      check("ov8",   32'(b8.out_valid), 32'(exp_v(k8)));
      check("fill8", 32'(b8.fill_cnt),  32'(exp_f(8)));
      check("q6",    32'(b6.q),         32'(exp_q(k6, RV6)));
      check("ov6",   32'(b6.out_valid), 32'(exp_v(k6)));
      check("fill6", 32'(b6.fill_cnt),  32'(exp_f(6)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input bit e, input bit v, input bit f,
                     input logic [7:0] dv, input logic [2:0] s);
    rst = r;  en = e;  iv = v;  fl = f;  d = dv;  sel = s;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE, 3'd7);
    chk_en = 1'b1;
    check("rst_q8",    32'(b8.q),         32'h3C);
    check("rst_q6",    32'(b6.q),         32'hC3);
    check("rst_ov8",   32'(b8.out_valid), VT ? 32'd0 : 32'd1);
    check("rst_fill8", 32'(b8.fill_cnt),  32'd0);

    // fill with 0x01..0x0A at the last tap
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'(i), 3'd7);
      if (i == 8) begin
        check("fill_q8_first", 32'(b8.q),         32'h01);
        check("fill_ov8",      32'(b8.out_valid), 32'd1);
        check("fill_q6_clamp", 32'(b6.q),         32'h03);
      end
      if (i == 10) begin
        check("fill_q8_third", 32'(b8.q),        32'h03);
        check("fill_sat8",     32'(b8.fill_cnt), VT ? 32'd8 : 32'd0);
        check("fill_sat6",     32'(b6.fill_cnt), VT ? 32'd6 : 32'd0);
      end
    end

    // en toggling, tap 3: A5 arrives after 4 enabled edges = 7 clocks
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 3'd3);
    for (int j = 2; j <= 8; j++) begin
      cyc(1'b0, 1'((j % 2) == 1 && j < 8), 1'b1, 1'b0, 8'(8'h10 + j), 3'd3);
      if (j == 7) check("tog_q8_arrive", 32'(b8.q), 32'hA5);
      if (j == 8) check("tog_q8_hold",   32'(b8.q), 32'hA5);
    end

    // frozen sweep: stages hold 17,15,13,A5,0A,09,08,07; d/in_valid ignored
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 3'(k));
      if (k == 0) check("sweep_q8_s0", 32'(b8.q), 32'h17);
      if (k == 4) check("sweep_q8_s4", 32'(b8.q), 32'h0A);
      if (k == 7) begin
        check("sweep_q8_s7",    32'(b8.q), 32'h07);
        check("sweep_q6_clamp", 32'(b6.q), 32'h09);
      end
    end

    // flush with en=1 mid-stream at tap 2
    for (int j = 0; j <= 5; j++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'(j == 2), 8'(8'h20 + j), 3'd2);
      if (j == 2) begin
        check("flush_ov8",   32'(b8.out_valid), VT ? 32'd0 : 32'd1);
        check("flush_fill8", 32'(b8.fill_cnt),  32'd0);
        check("flush_q8",    32'(b8.q),         32'h20);
      end
      if (j == 4) check("flush_ov8_wait", 32'(b8.out_valid), VT ? 32'd0 : 32'd1);
      if (j == 5) begin
        check("flush_ov8_back", 32'(b8.out_valid), 32'd1);
        check("flush_fill8_3",  32'(b8.fill_cnt),  VT ? 32'd3 : 32'd0);
        check("flush_q8_data",  32'(b8.q),         32'h23);
      end
    end

    // reset with flush and en while full: reset result only
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 3'd0);
    check("rstmid_q8",    32'(b8.q),         32'h3C);
    check("rstmid_q6",    32'(b6.q),         32'hC3);
    check("rstmid_ov8",   32'(b8.out_valid), VT ? 32'd0 : 32'd1);
    check("rstmid_fill8", 32'(b8.fill_cnt),  32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 3'd0);
    check("post_rst_q8",    32'(b8.q),        32'h5A);
    check("post_rst_fill8", 32'(b8.fill_cnt), VT ? 32'd1 : 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h66, 3'd7);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7);
    check("rst1_q8", 32'(b8.q), 32'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h99, 3'd0);

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
